prio_irq_encoder: RTL and testbench

Parametrised, registered priority encoder with latched requests, masking and a valid/ack handshake. It generalises the 8-to-3 active-low priority encoder to N channels with edge or level capture and one-at-a-time interrupt issue. It sits between raw active-low request lines and a consumer (CPU interface or sequencer) that services one channel per handshake. Cascade outputs `gs` and `eo` allow stacking of several instances.

---
 rtl/prio_irq_encoder.sv | 147 ++++++++++++++
 tb/tb_prio_irq_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/prio_irq_encoder.sv
// Purpose : N-channel registered priority encoder with latched requests, masking and valid/ack issue.
// Latency : req_n falling -> pending 1 clk; pending -> irq_valid/irq_id 1 clk (2 clk total); gs/eo 1 clk after pending.
// Backpr. : one interrupt outstanding; irq_valid/irq_id hold until ack; further requests stay pending meanwhile.
//
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_en           issue enable (capture is never gated)
//   i_req_n[N]     active-low requests, bit N-1 has the highest priority
//   i_mask[N]      1 = channel excluded from arbitration (still captured)
//   i_ack          consumer accepts the presented interrupt
//   o_irq_valid    interrupt presented on o_irq_id
//   o_irq_id[W]    binary index of the presented channel
//   o_gs, o_eo     cascade group select / enable out for a lower-priority stage
module prio_irq_encoder #(
    parameter  int N    = 8,
    parameter  bit EDGE = 1'b1,
    localparam int W    = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [N-1:0] i_req_n,
    input  logic [N-1:0] i_mask,
    input  logic         i_ack,
    output logic         o_irq_valid,
    output logic [W-1:0] o_irq_id,
    output logic         o_gs,
    output logic         o_eo
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_req_s;
    logic [N-1:0]   r_pending;
    logic [W-1:0]   r_irq_id;
    logic           r_gs;
    logic           r_eo;

    logic [N-1:0]   w_eff;
    logic           w_any;
    logic [W-1:0]   w_win_id;
    logic [N-1:0]   w_new;
    logic [N-1:0]   w_clr;
    logic           w_load_id;

    assign w_eff = r_pending & ~i_mask;
    assign w_any = |w_eff;

    // Highest set index wins: later iterations overwrite earlier ones.
    always_comb begin
        w_win_id = '0;
        for (int i = 0; i < N; i++) begin
            if (w_eff[i]) begin
                w_win_id = W'(i);
            end
        end
    end

    // A request is new when it is asserted now but was not asserted last cycle.
    assign w_new = ~i_req_n & ~r_req_s;

    always_comb begin
        w_clr = '0;
        if (r_state == ST_ISSUE && i_ack) begin
            w_clr[r_irq_id] = 1'b1;
        end
    end

    // Request synchroniser stage and pending capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req_s   <= '0;
            r_pending <= '0;
        end else begin
            r_req_s <= ~i_req_n;
            if (EDGE) begin
                // Set after clear: an edge landing on the ack cycle is kept.
                r_pending <= (r_pending & ~w_clr) | w_new;
            end else begin
                r_pending <= ~i_req_n;
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic. ISSUE is left only on ack.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_en && w_any) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs. The winner is frozen only on the IDLE->ISSUE transition,
    // so mask/en/request changes during ISSUE cannot retract it.
    always_comb begin
        w_load_id   = (r_state == ST_IDLE) && (w_state_nxt == ST_ISSUE);
        o_irq_valid = (r_state == ST_ISSUE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq_id <= '0;
        end else if (w_load_id) begin
            r_irq_id <= w_win_id;
        end
    end

    // Cascade outputs track en/eff every cycle, independent of the FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gs <= 1'b0;
            r_eo <= 1'b0;
        end else begin
            r_gs <= i_en & w_any;
            r_eo <= i_en & ~w_any;
        end
    end

    assign o_irq_id = r_irq_id;
    assign o_gs     = r_gs;
    assign o_eo     = r_eo;

endmodule

// File: tb/tb_prio_irq_encoder.sv
module tb_prio_irq_encoder;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] req_n;
    logic [N-1:0] mask;
    logic         ack;

    logic         e_valid, l_valid;
    logic [W-1:0] e_id, l_id;
    logic         e_gs, l_gs, e_eo, l_eo;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    // Edge-capture instance (main DUT).
    prio_irq_encoder #(.N(N), .EDGE(1'b1)) u_dut_edge (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_req_n    (req_n),
        .i_mask     (mask),
        .i_ack      (ack),
        .o_irq_valid(e_valid),
        .o_irq_id   (e_id),
        .o_gs       (e_gs),
        .o_eo       (e_eo)
    );

    // Level-capture instance sharing the same stimulus.
    prio_irq_encoder #(.N(N), .EDGE(1'b0)) u_dut_level (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_req_n    (req_n),
        .i_mask     (mask),
        .i_ack      (ack),
        .o_irq_valid(l_valid),
        .o_irq_id   (l_id),
        .o_gs       (l_gs),
        .o_eo       (l_eo)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [N-1:0] bits);
        req_n = ~bits;
        step(1);
        req_n = '1;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        req_n = '1;
        mask  = '0;
        ack   = 1'b0;
        step(2);
        check_val("rst_valid", e_valid, 0);
        check_val("rst_id",    e_id,    0);
        check_val("rst_gs",    e_gs,    0);
        check_val("rst_eo",    e_eo,    0);
        rst = 1'b0;
        step(1);
        check_val("idle_eo", e_eo, 1);
        check_val("idle_gs", e_gs, 0);

        // Single request on bit 5.
        pulse_req(8'b0010_0000);
        check_val("t1_lat_valid", e_valid, 0);
        step(1);
        check_val("t1_valid", e_valid, 1);
        check_val("t1_id",    e_id,    5);
        check_val("t1_gs",    e_gs,    1);
        check_val("t1_eo",    e_eo,    0);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check_val("t1_ack_valid", e_valid, 0);
        step(1);
        check_val("t1_post_valid", e_valid, 0);
        check_val("t1_post_gs",    e_gs,    0);
        check_val("t1_post_eo",    e_eo,    1);

        // Bits 7, 6, 2 together, ack tied high.
        ack = 1'b1;
        pulse_req(8'b1100_0100);
        step(1);
        check_val("t2_v1",  e_valid, 1);
        check_val("t2_id1", e_id,    7);
        step(1);
        check_val("t2_gap1", e_valid, 0);
        step(1);
        check_val("t2_v2",  e_valid, 1);
        check_val("t2_id2", e_id,    6);
        step(1);
        check_val("t2_gap2", e_valid, 0);
        step(1);
        check_val("t2_v3",  e_valid, 1);
        check_val("t2_id3", e_id,    2);
        step(1);
        check_val("t2_gap3", e_valid, 0);
        ack = 1'b0;
        step(1);
        check_val("t2_done_valid", e_valid, 0);
        check_val("t2_done_gs",    e_gs,    0);

        // Masked channel 7, request on 7 and 3.
        mask = 8'h80;
        pulse_req(8'b1000_1000);
        step(1);
        check_val("t3_valid", e_valid, 1);
        check_val("t3_id",    e_id,    3);
        mask = 8'h00;
        step(2);
        check_val("t3_hold_valid", e_valid, 1);
        check_val("t3_hold_id",    e_id,    3);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check_val("t3_ack_valid", e_valid, 0);
        step(1);
        check_val("t3_next_valid", e_valid, 1);
        check_val("t3_next_id",    e_id,    7);
        ack = 1'b1;
        step(1);
        ack = 1'b0;

        // Issue disabled with bit 4 pending.
        en = 1'b0;
        pulse_req(8'b0001_0000);
        step(2);
        check_val("t4_dis_valid", e_valid, 0);
        check_val("t4_dis_gs",    e_gs,    0);
        check_val("t4_dis_eo",    e_eo,    0);
        en = 1'b1;
        step(1);
        check_val("t4_en_valid", e_valid, 1);
        check_val("t4_en_id",    e_id,    4);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(1);

        // New edge on bit 4 coinciding with its ack: set wins.
        pulse_req(8'b0001_0000);
        step(1);
        check_val("t5_valid", e_valid, 1);
        check_val("t5_id",    e_id,    4);
        ack      = 1'b1;
        req_n[4] = 1'b0;
        step(1);
        ack   = 1'b0;
        req_n = '1;
        check_val("t5_ack_valid", e_valid, 0);
        step(1);
        check_val("t5_reissue_valid", e_valid, 1);
        check_val("t5_reissue_id",    e_id,    4);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(1);

        // Level mode: bit 1 held low across ack re-issues; edge mode does not.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req_n[1] = 1'b0;
        step(2);
        check_val("t6_lvl_valid", l_valid, 1);
        check_val("t6_lvl_id",    l_id,    1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check_val("t6_lvl_ack_valid", l_valid, 0);
        step(1);
        check_val("t6_lvl_re_valid",  l_valid, 1);
        check_val("t6_lvl_re_id",     l_id,    1);
        check_val("t6_edge_no_re",    e_valid, 0);
        req_n = '1;
        ack   = 1'b1;
        step(1);
        ack = 1'b0;
        step(2);

        // Reset during ISSUE of channel 6, request held low throughout.
        req_n[6] = 1'b0;
        step(2);
        check_val("t7_valid", e_valid, 1);
        check_val("t7_id",    e_id,    6);
        rst = 1'b1;
        step(1);
        check_val("t7_rst_valid", e_valid, 0);
        check_val("t7_rst_id",    e_id,    0);
        check_val("t7_rst_gs",    e_gs,    0);
        check_val("t7_rst_eo",    e_eo,    0);
        rst = 1'b0;
        step(1);
        check_val("t7_cap_valid", e_valid, 0);
        step(1);
        check_val("t7_re_valid", e_valid, 1);
        check_val("t7_re_id",    e_id,    6);
        req_n = '1;
        ack   = 1'b1;
        step(1);
        ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
